mem_port_arbiter: RTL and testbench

//  Shares the single memory port (mem_operation/mem_opdone handshake) between NUM_REQ requesters,
//  e.g. the matrix-multiplication engine and the host bus. Round-robin grant, one transaction at a time.

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_port_arbiter_if.sv | 30 +++
 rtl/mem_port_arbiter_rr_pick.sv | 26 ++
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared memory-port definitions: operation codes, data width and arbiter state encoding.
// The matrix engine and the host adapter import the same package.
`ifndef TYPE_BW
`define TYPE_BW 32
`endif

package mem_port_arbiter_pkg;

  localparam logic [1:0] MEM_OP_NONE  = 2'b00;
  localparam logic [1:0] MEM_OP_READ  = 2'b01;
  localparam logic [1:0] MEM_OP_WRITE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

  // 01 and 11 are requests; 00 and the reserved 10 are not.
  function automatic logic op_active(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the requester-side and memory-side buses of the memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32
);
  // Handshake: a requester holds op/addr/wdata until its 1-cycle req_opdone; the arbiter holds
  // mem_* stable for a whole transaction and takes the 1-cycle mem_opdone as completion.
  logic [2*NUM_REQ-1:0]      req_operation;
  logic [ADDR_W*NUM_REQ-1:0] req_addr;
  logic [DATA_W*NUM_REQ-1:0] req_wdata;
  logic [DATA_W*NUM_REQ-1:0] req_rdata;
  logic [NUM_REQ-1:0]        req_opdone;
  logic [NUM_REQ-1:0]        req_err;
  logic [1:0]                mem_operation;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;
  logic                      mem_opdone;

  modport master (
    output req_operation, req_addr, req_wdata, mem_rdata, mem_opdone,
    input  req_rdata, req_opdone, req_err, mem_operation, mem_addr, mem_wdata
  );

  modport slave (
    input  req_operation, req_addr, req_wdata, mem_rdata, mem_opdone,
    output req_rdata, req_opdone, req_err, mem_operation, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Round-robin picker: first active requester at or after the pointer, wrapping around.
module mem_rr_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic               valid_o,
  output logic [IW-1:0]      idx_o
);

  // Scan from the farthest offset down so the nearest active requester wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[(int'(ptr_i) + i) % NUM_REQ]) begin
        valid_o = 1'b1;
        idx_o   = IW'((int'(ptr_i) + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between NUM_REQ requesters: round-robin grant, one registered
// downstream transaction at a time, 1-cycle opdone back, watchdog abort on a silent memory.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter  int NUM_REQ        = 2,
  parameter  int DATA_W         = `TYPE_BW,
  parameter  int ADDR_W         = 32,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int GW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_if.slave    bus,
  output logic                 busy,
  output logic [GW-1:0]        grant_id,
  output arb_state_e           dbg_state_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  arb_state_e          state_q;
  logic [1:0]          mem_op_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [GW-1:0]       grant_q;
  logic [GW-1:0]       rr_q;
  logic [NUM_REQ-1:0]  opdone_q;
  logic [NUM_REQ-1:0]  err_q;
  logic [DATA_W-1:0]   rdata_q [NUM_REQ];

  logic [1:0]          op_a    [NUM_REQ];
  logic [ADDR_W-1:0]   addr_a  [NUM_REQ];
  logic [DATA_W-1:0]   wdata_a [NUM_REQ];
  logic [NUM_REQ-1:0]  act;
  logic                pick_valid;
  logic [GW-1:0]       pick_idx;
  logic                timeout_hit;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign op_a[i]    = bus.req_operation[2*i +: 2];
    assign addr_a[i]  = bus.req_addr[ADDR_W*i +: ADDR_W];
    assign wdata_a[i] = bus.req_wdata[DATA_W*i +: DATA_W];
    assign act[i]     = op_active(op_a[i]);
    assign bus.req_rdata[DATA_W*i +: DATA_W] = rdata_q[i];
  end

  mem_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i   (act),
    .ptr_i   (rr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      mem_op_q    <= MEM_OP_NONE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      rr_q        <= '0;
      opdone_q    <= '0;
      err_q       <= '0;
      for (int i = 0; i < NUM_REQ; i++) rdata_q[i] <= '0;
    end else begin
      opdone_q <= '0;
      err_q    <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_q     <= pick_idx;
            mem_op_q    <= op_a[pick_idx];
            mem_addr_q  <= addr_a[pick_idx];
            mem_wdata_q <= wdata_a[pick_idx];
            cnt_q       <= '0;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // A real acknowledge wins over a watchdog expiry in the same cycle.
          if (bus.mem_opdone) begin
            if (mem_op_q == MEM_OP_READ) rdata_q[grant_q] <= bus.mem_rdata;
            mem_op_q          <= MEM_OP_NONE;
            opdone_q[grant_q] <= 1'b1;
            state_q           <= ST_RESP;
          end else if (timeout_hit) begin
            rdata_q[grant_q]  <= '0;
            mem_op_q          <= MEM_OP_NONE;
            opdone_q[grant_q] <= 1'b1;
            err_q[grant_q]    <= 1'b1;
            state_q           <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          rr_q    <= (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_operation = mem_op_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.req_opdone    = opdone_q;
  assign bus.req_err       = err_q;
  assign busy              = (state_q != ST_IDLE);
  assign grant_id          = grant_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: memory responder with an expected-transaction queue,
// single read, contention/rotation, burst fetch, write, watchdog timeout and mid-transaction reset.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int NR = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) bus ();
  logic       busy;
  logic [0:0] grant_id;
  arb_state_e dbg_state;

  mem_port_arbiter #(
    .NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .grant_id    (grant_id),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_tests   = 0;
  int          n_fail    = 0;
  logic [65:0] exp_q[$];
  int          mem_lat   = 2;
  logic        ack_en    = 1'b1;
  logic [31:0] rd_base   = '0;
  int          n_mem_txn = 0;

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic req_set(input int i, input logic [1:0] op, input logic [31:0] addr,
                         input logic [31:0] wd);
    bus.req_operation[2*i +: 2] = op;
    bus.req_addr[32*i +: 32]    = addr;
    bus.req_wdata[32*i +: 32]   = wd;
    if (op[0]) exp_q.push_back({op, addr, wd});
  endtask

  task automatic wait_done(input string tag, output logic [1:0] done_v);
    done_v = '0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.req_opdone != '0) begin
        done_v = bus.req_opdone;
        break;
      end
    end
    check({tag, "_seen"}, 66'(done_v != '0), 66'(1'b1));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // ---------------- memory responder ----------------
  initial begin
    int busy_cnt;
    busy_cnt       = 0;
    bus.mem_opdone = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(posedge clk); #1;
      bus.mem_opdone = 1'b0;
      if (bus.mem_operation != MEM_OP_NONE) begin
        if (exp_q.size() == 0) check("mem_unexpected", 66'(exp_q.size()), 66'(1));
        else check("mem_bus", {bus.mem_operation, bus.mem_addr, bus.mem_wdata}, exp_q[0]);
        if (busy_cnt == 0) n_mem_txn++;
        busy_cnt++;
        if (ack_en && busy_cnt == mem_lat) begin
          bus.mem_opdone = 1'b1;
          bus.mem_rdata  = rd_base + bus.mem_addr;
        end
      end else begin
        if (busy_cnt != 0 && exp_q.size() > 0) void'(exp_q.pop_front());
        busy_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [1:0] dv;
    logic [1:0] seen;
    int         cyc;
    int         txn_base;

    bus.req_operation = '0;
    bus.req_addr      = '0;
    bus.req_wdata     = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    check("rst_busy",   66'(busy), 66'(0));
    check("rst_memop",  66'(bus.mem_operation), 66'(MEM_OP_NONE));
    check("rst_opdone", 66'(bus.req_opdone), 66'(0));
    check("rst_rdata",  66'(bus.req_rdata), 66'(0));
    check("rst_grant",  66'(grant_id), 66'(0));
    check("rst_state",  66'(dbg_state), 66'(ST_IDLE));
    @(posedge clk); #1;
    reset = 1'b1;

    // 1. single read, addr 0x6 -> 0x1234
    rd_base = 32'h0000_122E;
    req_set(0, MEM_OP_READ, 32'h6, 32'h0);
    @(posedge clk); #1;
    check("t1_memop", 66'(bus.mem_operation), 66'(MEM_OP_READ));
    check("t1_addr",  66'(bus.mem_addr), 66'(32'h6));
    check("t1_busy",  66'(busy), 66'(1));
    wait_done("t1", dv);
    check("t1_done_vec", 66'(dv), 66'(2'b01));
    check("t1_rdata",    66'(bus.req_rdata[31:0]), 66'(32'h1234));
    check("t1_err",      66'(bus.req_err), 66'(0));
    req_set(0, MEM_OP_NONE, 32'h6, 32'h0);
    @(posedge clk); #1;
    check("t1_pulse", 66'(bus.req_opdone), 66'(0));
    check("t1_idle",  66'(busy), 66'(0));

    // 2. contention from pointer 0, then rotation
    do_reset();
    rd_base = 32'h0000_1000;
    req_set(0, MEM_OP_READ, 32'h10, 32'h0);
    req_set(1, MEM_OP_READ, 32'h11, 32'h0);
    wait_done("t2a", dv);
    check("t2_first",  66'(dv), 66'(2'b01));
    check("t2_grant0", 66'(grant_id), 66'(0));
    check("t2_rdata0", 66'(bus.req_rdata[31:0]), 66'(32'h1010));
    req_set(0, MEM_OP_READ, 32'h12, 32'h0);
    wait_done("t2b", dv);
    check("t2_second", 66'(dv), 66'(2'b10));
    check("t2_grant1", 66'(grant_id), 66'(1));
    check("t2_rdata1", 66'(bus.req_rdata[63:32]), 66'(32'h1011));
    req_set(1, MEM_OP_NONE, 32'h11, 32'h0);
    wait_done("t2c", dv);
    check("t2_third",   66'(dv), 66'(2'b01));
    check("t2_rdata0b", 66'(bus.req_rdata[31:0]), 66'(32'h1012));
    req_set(0, MEM_OP_NONE, 32'h12, 32'h0);

    // 3. burst fetch at addr 1..4 with op held
    rd_base  = 32'h0000_2000;
    txn_base = n_mem_txn;
    req_set(0, MEM_OP_READ, 32'h1, 32'h0);
    for (int a = 1; a <= 4; a++) begin
      wait_done("t3", dv);
      check("t3_done",  66'(dv), 66'(2'b01));
      check("t3_rdata", 66'(bus.req_rdata[31:0]), 66'(32'h2000 + 32'(a)));
      if (a < 4) req_set(0, MEM_OP_READ, 32'(a + 1), 32'h0);
      else       req_set(0, MEM_OP_NONE, 32'(a), 32'h0);
    end
    repeat (6) @(posedge clk);
    #1;
    check("t3_txn_count", 66'(n_mem_txn - txn_base), 66'(4));
    check("t3_queue",     66'(exp_q.size()), 66'(0));
    check("t3_idle",      66'(busy), 66'(0));

    // 4. write from requester 1
    req_set(1, MEM_OP_WRITE, 32'h20, 32'h0000_BEEF);
    @(posedge clk); #1;
    check("t4_memop", 66'(bus.mem_operation), 66'(MEM_OP_WRITE));
    check("t4_wdata", 66'(bus.mem_wdata), 66'(32'hBEEF));
    check("t4_addr",  66'(bus.mem_addr), 66'(32'h20));
    check("t4_grant", 66'(grant_id), 66'(1));
    wait_done("t4", dv);
    check("t4_done",  66'(dv), 66'(2'b10));
    check("t4_rdata", 66'(bus.req_rdata[63:32]), 66'(32'h1011));
    check("t4_err",   66'(bus.req_err), 66'(0));
    req_set(1, MEM_OP_NONE, 32'h20, 32'h0);

    // 5. watchdog timeout with a silent memory
    ack_en = 1'b0;
    req_set(0, MEM_OP_READ, 32'h30, 32'h0);
    cyc = 0;
    dv  = '0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (bus.mem_operation != MEM_OP_NONE) cyc++;
      if (bus.req_opdone != '0) begin
        dv = bus.req_opdone;
        break;
      end
    end
    check("t5_issue_cycles", 66'(cyc), 66'(8));
    check("t5_done",  66'(dv), 66'(2'b01));
    check("t5_err",   66'(bus.req_err), 66'(2'b01));
    check("t5_rdata", 66'(bus.req_rdata[31:0]), 66'(0));
    req_set(0, MEM_OP_NONE, 32'h30, 32'h0);
    @(posedge clk); #1;
    check("t5_err_pulse", 66'(bus.req_err), 66'(0));
    ack_en = 1'b1;

    // 6. reset in the middle of a transaction
    mem_lat = 4;
    req_set(1, MEM_OP_READ, 32'h40, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("t6_pre_busy", 66'(busy), 66'(1));
    reset = 1'b0;
    #1;
    check("t6_memop", 66'(bus.mem_operation), 66'(MEM_OP_NONE));
    check("t6_busy",  66'(busy), 66'(0));
    check("t6_rdata", 66'(bus.req_rdata), 66'(0));
    check("t6_grant", 66'(grant_id), 66'(0));
    check("t6_state", 66'(dbg_state), 66'(ST_IDLE));
    req_set(1, MEM_OP_NONE, 32'h40, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    seen = '0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      seen = seen | bus.req_opdone;
    end
    check("t6_no_opdone", 66'(seen), 66'(0));
    mem_lat = 2;
    rd_base = 32'h0000_3000;
    req_set(1, MEM_OP_READ, 32'h44, 32'h0);
    wait_done("t6", dv);
    check("t6_done",  66'(dv), 66'(2'b10));
    check("t6_grant_after", 66'(grant_id), 66'(1));
    check("t6_rdata_after", 66'(bus.req_rdata[63:32]), 66'(32'h3044));
    req_set(1, MEM_OP_NONE, 32'h44, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    check("final_queue", 66'(exp_q.size()), 66'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
